mouse_pos_filter: RTL

MOUSE_POS_FILTER -- requirements
Module: mouse_pos_filter

---
 rtl/mouse_pkg.sv | 18 +
 rtl/pos_clamp.sv | 18 +
 rtl/mouse_pos_filter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mouse_pkg.sv
// Shared widths, position payload and filter state type for the mouse position filter.
package mouse_pkg;

    localparam int unsigned POS_W = 12;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        COMMIT  = 2'd2
    } mouse_filt_state_t;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
    } mouse_pos_t;

endpackage

// File: rtl/pos_clamp.sv
// Saturates one unsigned coordinate at MAX; purely combinational.
module pos_clamp
    import mouse_pkg::*;
#(
    parameter int unsigned MAX = 799
) (
    input  logic [POS_W-1:0] val_i,
    output logic [POS_W-1:0] val_c_o
);

    localparam logic [POS_W-1:0] MAX_V = POS_W'(MAX);

    // Unsigned compare, so large raw values saturate instead of wrapping.
    always_comb begin
        val_c_o = (val_i > MAX_V) ? MAX_V : val_i;
    end

endmodule

// File: rtl/mouse_pos_filter.sv
// Debounces the synchronized mouse position, clamps it to the screen and
// commits it only after it has been stable; also edge-detects the left button.
module mouse_pos_filter
    import mouse_pkg::*;
#(
    parameter int unsigned X_MAX         = 799,
    parameter int unsigned Y_MAX         = 599,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [POS_W-1:0] xpos_bf2,
    input  logic [POS_W-1:0] ypos_bf2,
    input  logic             left_bf2,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    output logic             pos_update,
    output logic             click
);

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

    mouse_filt_state_t state_q, state_d;
    mouse_pos_t        cand_q, cand_d;
    mouse_pos_t        pos_q, pos_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pos_update_q, pos_update_d;
    logic              left_prev_q;
    logic              click_q, click_d;

    mouse_pos_t raw_c;
    mouse_pos_t clamp_src_c;
    mouse_pos_t clamp_c;
    logic       in_changed_c;

    assign raw_c        = {xpos_bf2, ypos_bf2};
    assign in_changed_c = (raw_c != cand_q);

    // IDLE judges the live input; QUALIFY/COMMIT judge the held candidate.
    assign clamp_src_c = (state_q == IDLE) ? raw_c : cand_q;

    pos_clamp #(.MAX(X_MAX)) u_clamp_x (
        .val_i   (clamp_src_c.x),
        .val_c_o (clamp_c.x)
    );

    pos_clamp #(.MAX(Y_MAX)) u_clamp_y (
        .val_i   (clamp_src_c.y),
        .val_c_o (clamp_c.y)
    );

    // Candidate sampling and saturating stability counter.
    always_comb begin
        cand_d = raw_c;
        cnt_d  = cnt_q;
        if (in_changed_c) begin
            cnt_d = '0;
        end else if (cnt_q < STABLE_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Next-state and registered-output logic of the qualify/commit FSM.
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        pos_update_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_changed_c && (clamp_c != pos_q)) begin
                    state_d = QUALIFY;
                end
            end
            QUALIFY: begin
                if (in_changed_c) begin
                    state_d = QUALIFY;
                end else if (cnt_q == STABLE_MAX) begin
                    if (clamp_c == pos_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = COMMIT;
                        pos_d        = clamp_c;
                        pos_update_d = 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Left-button rising-edge detect, independent of the FSM.
    always_comb begin
        click_d = left_bf2 & ~left_prev_q;
    end

    // State and output registers; left_prev resets high to swallow a button held through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cand_q       <= '0;
            cnt_q        <= '0;
            pos_q        <= '0;
            pos_update_q <= 1'b0;
            left_prev_q  <= 1'b1;
            click_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            pos_q        <= pos_d;
            pos_update_q <= pos_update_d;
            left_prev_q  <= left_bf2;
            click_q      <= click_d;
        end
    end

    assign xpos       = pos_q.x;
    assign ypos       = pos_q.y;
    assign pos_update = pos_update_q;
    assign click      = click_q;

endmodule
